// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared widths, R-type field positions and ALU funct codes.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int FUNCT_W    = 6;

  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b001001;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b001010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'b100001;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;

  function automatic logic is_legal_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_SLL) || (f == FUNCT_OR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_2r1w: two combinational read ports, one write port, r0      |
// | hard-wired to zero, same-cycle write-through bypass on both reads.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_file_2r1w #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_en,
  input  logic [4:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [4:0]        i_ra_addr,
  input  logic [4:0]        i_rb_addr,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data
);

  logic [DATA_W-1:0] r_mem [0:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wb_en && (i_wb_addr != '0)) begin
      r_mem[i_wb_addr] <= i_wb_data;
    end
  end

  // The bypass lets an instruction read a value being written back this cycle.
  always_comb begin
    o_ra_data = r_mem[i_ra_addr];
    if (i_ra_addr == '0) begin
      o_ra_data = '0;
    end else if (i_wb_en && (i_wb_addr == i_ra_addr)) begin
      o_ra_data = i_wb_data;
    end
  end

  always_comb begin
    o_rb_data = r_mem[i_rb_addr];
    if (i_rb_addr == '0) begin
      o_rb_data = '0;
    end else if (i_wb_en && (i_wb_addr == i_rb_addr)) begin
      o_rb_data = i_wb_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_operand_stage: decode / operand fetch in front of the ALU, with a |
// | valid/ready output register, flush and write-back snooping.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_operand_stage #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instr,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic [4:0]        Shamt,
  output logic [5:0]        Funct,
  output logic [4:0]        rd,
  output logic              illegal
);

  import cpu_pkg::*;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_capture;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_unused_opcode;

  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [4:0]        r_shamt;
  logic [5:0]        r_funct;
  logic [4:0]        r_rd;
  logic              r_illegal;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;

  assign w_rs            = Instr[RS_MSB:RS_LSB];
  assign w_rt            = Instr[RT_MSB:RT_LSB];
  assign w_unused_opcode = ^Instr[31:26];

  reg_file_2r1w #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wb_en   (wb_en),
    .i_wb_addr (wb_addr),
    .i_wb_data (wb_data),
    .i_ra_addr (w_rs),
    .i_rb_addr (w_rt),
    .o_ra_data (w_rs_val),
    .o_rb_data (w_rt_val)
  );

  assign in_ready  = (r_state == S_EMPTY) || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else if (w_capture) begin
      w_state_nxt = S_FULL;
    end else if ((r_state == S_FULL) && out_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_comb begin
    out_valid = (r_state == S_FULL);
  end

  // A stalled instruction picks up write-backs to its sources so it never issues stale operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in1     <= '0;
      r_in2     <= '0;
      r_shamt   <= '0;
      r_funct   <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
    end else if (w_capture) begin
      r_in1     <= w_rs_val;
      r_in2     <= w_rt_val;
      r_shamt   <= Instr[SHAMT_MSB:SHAMT_LSB];
      r_funct   <= Instr[FUNCT_MSB:FUNCT_LSB];
      r_rd      <= Instr[RD_MSB:RD_LSB];
      r_illegal <= !is_legal_funct(Instr[FUNCT_MSB:FUNCT_LSB]);
      r_rs      <= w_rs;
      r_rt      <= w_rt;
    end else if ((r_state == S_FULL) && !out_ready) begin
      if (wb_en && (wb_addr != '0) && (wb_addr == r_rs)) begin
        r_in1 <= wb_data;
      end
      if (wb_en && (wb_addr != '0) && (wb_addr == r_rt)) begin
        r_in2 <= wb_data;
      end
    end
  end

  assign in1     = r_in1;
  assign in2     = r_in2;
  assign Shamt   = r_shamt;
  assign Funct   = r_funct;
  assign rd      = r_rd;
  assign illegal = r_illegal;

endmodule
`default_nettype wire
